// File: rtl/div_recombiner.sv
// Rebuilds dividend A = Q*B + R with a shift-and-add multiplier plus a remainder add.
// Optional feature: RECOMBINE_CHECK_EN registers a remainder-consistency flag (r < b, b != 0).
module div_recombiner #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] q_in,
  input  logic [W-1:0] b_in,
  input  logic [W-1:0] r_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] dividend_lo,
  output logic [W-1:0] dividend_hi,
  output logic         rem_ok
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADD
  } state_t;

  state_t state, state_n;

  logic [W-1:0]   q, b, r;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  count;
  logic [2*W-1:0] part;
  logic [2*W-1:0] sum;
  logic           last;

  assign last = (count == CW'(W - 1));
  assign part = q[count] ? ({{W{1'b0}}, b} << count) : '0;
  assign sum  = acc + {{W{1'b0}}, r};
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = MUL;
      MUL:     if (last) state_n = ADD;
      ADD:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q           <= '0;
      b           <= '0;
      r           <= '0;
      acc         <= '0;
      count       <= '0;
      done        <= 1'b0;
      dividend_lo <= '0;
      dividend_hi <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            q     <= q_in;
            b     <= b_in;
            r     <= r_in;
            acc   <= '0;
            count <= '0;
          end
        end
        MUL: begin
          acc   <= acc + part;
          count <= count + CW'(1);
        end
        ADD: begin
          acc         <= sum;
          dividend_lo <= sum[W-1:0];
          dividend_hi <= sum[2*W-1:W];
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RECOMBINE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            rem_ok <= 1'b0;
    else if (state == ADD) rem_ok <= (r < b) && (b != '0);
  end
`else
  assign rem_ok = 1'b0;
`endif

endmodule

// File: tb/tb_div_recombiner.sv
// Directed scoreboard bench for div_recombiner.
// Expected results are queued at start and popped when done pulses.
module tb_div_recombiner;

  localparam int W = 9;

  typedef struct {
    int res;
    bit rok;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] q_in, b_in, r_in;
  logic         busy, done, rem_ok;
  logic [W-1:0] dividend_lo, dividend_hi;

  int   tests;
  int   fails;
  exp_t sb[$];

  div_recombiner #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .q_in        (q_in),
    .b_in        (b_in),
    .r_in        (r_in),
    .busy        (busy),
    .done        (done),
    .dividend_lo (dividend_lo),
    .dividend_hi (dividend_hi),
    .rem_ok      (rem_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int q, input int b, input int r,
                        input bit hold);
    exp_t e;
    e.res = q * b + r;
`ifdef RECOMBINE_CHECK_EN
    e.rok = (r < b) && (b != 0);
`else
    e.rok = 1'b0;
`endif
    sb.push_back(e);
    q_in  = W'(q);
    b_in  = W'(b);
    r_in  = W'(r);
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
  endtask

  // Waits for done; lat is the number of edges expected until it is seen.
  task automatic wait_result(input string tag, input int lat);
    int   n;
    bit   seen;
    bit   early;
    exp_t e;
    n     = 0;
    seen  = 1'b0;
    early = 1'b0;
    while (!seen && n < lat + 5) begin
      if (busy !== 1'b1) early = 1'b1;
      step();
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, " busy_held"}, int'(early), 0);
    check({tag, " latency"}, n, lat);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " result"}, int'({dividend_hi, dividend_lo}), e.res);
      check({tag, " rem_ok"}, int'(rem_ok), int'(e.rok));
      check({tag, " busy_in_done"}, int'(busy), 0);
    end else begin
      check({tag, " no_done_or_empty_sb"}, 0, 1);
    end
  endtask

  initial begin
    int dcount;
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    q_in   = '0;
    b_in   = '0;
    r_in   = '0;
    #12;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset lo", int'(dividend_lo), 0);
    check("reset hi", int'(dividend_hi), 0);
    check("reset rem_ok", int'(rem_ok), 0);
    step();
    rst_n = 1'b1;
    step();

    // Basic
    launch(2, 9, 5, 1'b0);
    check("basic busy_after_start", int'(busy), 1);
    wait_result("basic", 10);
    check("basic lo", int'(dividend_lo), 23);
    check("basic hi", int'(dividend_hi), 0);
    step();
    check("basic done_one_cycle", int'(done), 0);
    check("basic hold_lo", int'(dividend_lo), 23);

    // Max operands
    launch(511, 511, 511, 1'b0);
    wait_result("max", 10);
    check("max lo", int'(dividend_lo), 0);
    check("max hi", int'(dividend_hi), 511);
    step();

    // Start while busy is ignored
    launch(3, 4, 1, 1'b0);
    repeat (3) step();
    q_in  = 9'd7;
    b_in  = 9'd9;
    r_in  = 9'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_result("busy_start", 6);
    dcount = 0;
    repeat (14) begin
      step();
      if (done === 1'b1) dcount++;
    end
    check("busy_start extra_done", dcount, 0);
    check("busy_start hold", int'({dividend_hi, dividend_lo}), 13);

    // Back-to-back with start held high
    launch(10, 10, 0, 1'b1);
    q_in = 9'd0;
    b_in = 9'd0;
    r_in = 9'd6;
    begin
      exp_t e;
      e.res = 6;
      e.rok = 1'b0;
      sb.push_back(e);
    end
    wait_result("b2b first", 10);
    step();
    start = 1'b0;
    check("b2b relaunch busy", int'(busy), 1);
    wait_result("b2b second", 10);
    step();

    // Asynchronous reset mid-operation
    q_in  = 9'd5;
    b_in  = 9'd5;
    r_in  = 9'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset busy", int'(busy), 0);
    check("midreset done", int'(done), 0);
    check("midreset lo", int'(dividend_lo), 0);
    check("midreset hi", int'(dividend_hi), 0);
    check("midreset rem_ok", int'(rem_ok), 0);
    dcount = 0;
    repeat (3) begin
      step();
      if (done === 1'b1) dcount++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      step();
      if (done === 1'b1) dcount++;
    end
    check("midreset no_done", dcount, 0);
    launch(1, 9, 9, 1'b0);
    wait_result("after_reset", 10);
    check("after_reset rem_ok_zero", int'(rem_ok), 0);
    step();

    check("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
